// File: rtl/pipe_hazard_ctrl_if.sv
// pipe_hazard_ctrl_if: hazard detection inputs and pipeline control outputs
// shared between the pipeline datapath (master) and the hazard sequencer (slave).
interface pipe_hazard_ctrl_if #(parameter int CNT_W = 16);
    logic             idex_memread;
    logic [4:0]       idex_rt;
    logic [4:0]       ifid_rs;
    logic [4:0]       ifid_rt;
    logic             branch_taken;
    logic             mem_busy;
    logic             pc_write;
    logic             ifid_write;
    logic             ifid_flush;
    logic             idex_bubble;
    logic             exmem_flush;
    logic             pipe_hold;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;
    modport master (
        output idex_memread, idex_rt, ifid_rs, ifid_rt, branch_taken, mem_busy,
        input  pc_write, ifid_write, ifid_flush, idex_bubble, exmem_flush, pipe_hold,
        input  stall_cnt, flush_cnt
    );
    modport slave (
        input  idex_memread, idex_rt, ifid_rs, ifid_rt, branch_taken, mem_busy,
        output pc_write, ifid_write, ifid_flush, idex_bubble, exmem_flush, pipe_hold,
        output stall_cnt, flush_cnt
    );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: load-use / taken-branch / memory-wait sequencer for the
// 5-stage pipeline, with saturating stall and flush counters.
module pipe_hazard_ctrl #(
    parameter int LU_BUBBLES = 1,
    parameter int CNT_W      = 16
) (
    input logic               clk_i,
    input logic               rst_i,
    pipe_hazard_ctrl_if.slave hz
);
    typedef enum logic [1:0] {RUN, LU_STALL, MEM_WAIT} state_t;
    state_t           state, eff;
    logic [2:0]       bub_cnt;
    logic [CNT_W-1:0] stall_q, flush_q;
    logic             hazard_lu, lu, br, busy, pc_wr;
    // A released memory wait acts in that same cycle as the state it resumes.
    always_comb begin
        hazard_lu = hz.idex_memread && hz.idex_rt != 5'd0 &&
                    (hz.idex_rt == hz.ifid_rs || hz.idex_rt == hz.ifid_rt);
        br        = hz.branch_taken;
        busy      = hz.mem_busy;
        eff       = state == MEM_WAIT ? (bub_cnt != 3'd0 ? LU_STALL : RUN) : state;
        lu        = eff == LU_STALL || (eff == RUN && hazard_lu);
        pc_wr     = br || (!busy && !lu);
    end
    assign hz.pc_write    = !rst_i || pc_wr;
    assign hz.ifid_write  = !rst_i || pc_wr;
    assign hz.ifid_flush  = rst_i && br;
    assign hz.exmem_flush = rst_i && br;
    assign hz.idex_bubble = rst_i && (br || (!busy && lu));
    assign hz.pipe_hold   = rst_i && !br && busy;
    assign hz.stall_cnt   = rst_i ? stall_q : '0;
    assign hz.flush_cnt   = rst_i ? flush_q : '0;
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state   <= RUN;
            bub_cnt <= 3'd0;
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            if (!pc_wr)
                stall_q <= stall_q + {{(CNT_W-1){1'b0}}, ~&stall_q};
            if (br) begin
                state   <= RUN;
                bub_cnt <= 3'd0;
                flush_q <= flush_q + {{(CNT_W-1){1'b0}}, ~&flush_q};
            end else if (busy) begin
                state <= MEM_WAIT;
            end else if (eff == LU_STALL) begin
                bub_cnt <= bub_cnt - 3'd1;
                state   <= bub_cnt == 3'd1 ? RUN : LU_STALL;
            end else if (lu) begin
                bub_cnt <= 3'(LU_BUBBLES - 1);
                state   <= LU_BUBBLES > 1 ? LU_STALL : RUN;
            end else begin
                state <= RUN;
            end
        end
    end
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: scoreboard bench over three configurations
// (LU_BUBBLES=1, LU_BUBBLES=3, LU_BUBBLES=3 with 4-bit counters).
module tb_pipe_hazard_ctrl;
    localparam logic [5:0] IDLE = 6'b110000;
    localparam logic [5:0] BUB  = 6'b000100;
    localparam logic [5:0] FL   = 6'b111110;
    localparam logic [5:0] HLD  = 6'b000001;
    typedef struct {
        string       tag;
        int          sel;
        logic [5:0]  ctl;
        logic [15:0] sc;
        logic [15:0] fc;
    } exp_t;
    exp_t q[$];
    int   n_cmp = 0;
    int   n_err = 0;
    logic clk_i = 1'b0;
    logic rst_n = 1'b0;
    int   sel = 0;
    logic memrd = 1'b0, brt = 1'b0, bsy = 1'b0;
    logic [4:0] rt = '0, rs = '0, rtt = '0;
    always #5 clk_i = ~clk_i;
    pipe_hazard_ctrl_if #(.CNT_W(16)) i0 ();
    pipe_hazard_ctrl_if #(.CNT_W(16)) i1 ();
    pipe_hazard_ctrl_if #(.CNT_W(4))  i2 ();
    assign i0.idex_memread = sel == 0 && memrd;
    assign i0.idex_rt      = sel == 0 ? rt : 5'd0;
    assign i0.ifid_rs      = sel == 0 ? rs : 5'd0;
    assign i0.ifid_rt      = sel == 0 ? rtt : 5'd0;
    assign i0.branch_taken = sel == 0 && brt;
    assign i0.mem_busy     = sel == 0 && bsy;
    assign i1.idex_memread = sel == 1 && memrd;
    assign i1.idex_rt      = sel == 1 ? rt : 5'd0;
    assign i1.ifid_rs      = sel == 1 ? rs : 5'd0;
    assign i1.ifid_rt      = sel == 1 ? rtt : 5'd0;
    assign i1.branch_taken = sel == 1 && brt;
    assign i1.mem_busy     = sel == 1 && bsy;
    assign i2.idex_memread = sel == 2 && memrd;
    assign i2.idex_rt      = sel == 2 ? rt : 5'd0;
    assign i2.ifid_rs      = sel == 2 ? rs : 5'd0;
    assign i2.ifid_rt      = sel == 2 ? rtt : 5'd0;
    assign i2.branch_taken = sel == 2 && brt;
    assign i2.mem_busy     = sel == 2 && bsy;
    pipe_hazard_ctrl #(.LU_BUBBLES(1), .CNT_W(16)) u0 (.clk_i(clk_i), .rst_i(rst_n), .hz(i0.slave));
    pipe_hazard_ctrl #(.LU_BUBBLES(3), .CNT_W(16)) u1 (.clk_i(clk_i), .rst_i(rst_n), .hz(i1.slave));
    pipe_hazard_ctrl #(.LU_BUBBLES(3), .CNT_W(4))  u2 (.clk_i(clk_i), .rst_i(rst_n), .hz(i2.slave));
    logic [5:0]  oc [3];
    logic [15:0] os [3];
    logic [15:0] of [3];
    assign oc[0] = {i0.pc_write, i0.ifid_write, i0.ifid_flush, i0.idex_bubble, i0.exmem_flush, i0.pipe_hold};
    assign oc[1] = {i1.pc_write, i1.ifid_write, i1.ifid_flush, i1.idex_bubble, i1.exmem_flush, i1.pipe_hold};
    assign oc[2] = {i2.pc_write, i2.ifid_write, i2.ifid_flush, i2.idex_bubble, i2.exmem_flush, i2.pipe_hold};
    assign os[0] = i0.stall_cnt;
    assign os[1] = i1.stall_cnt;
    assign os[2] = {12'd0, i2.stall_cnt};
    assign of[0] = i0.flush_cnt;
    assign of[1] = i1.flush_cnt;
    assign of[2] = {12'd0, i2.flush_cnt};
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask
    task automatic cyc(input string tag, input int s, input logic r, input logic ld,
                       input logic [4:0] a_rt, input logic [4:0] a_rs, input logic [4:0] a_rtt,
                       input logic b, input logic bz, input logic [5:0] ec,
                       input logic [15:0] es, input logic [15:0] ef);
        @(posedge clk_i);
        #1;
        sel = s; rst_n = r; memrd = ld; rt = a_rt; rs = a_rs; rtt = a_rtt; brt = b; bsy = bz;
        q.push_back('{tag, s, ec, es, ef});
    endtask
    always @(negedge clk_i) begin
        if (q.size() != 0) begin
            exp_t e;
            e = q.pop_front();
            check({e.tag, ".ctl"}, 32'(oc[e.sel]), 32'(e.ctl));
            check({e.tag, ".stall"}, 32'(os[e.sel]), 32'(e.sc));
            check({e.tag, ".flush"}, 32'(of[e.sel]), 32'(e.fc));
        end
    end
    initial begin
        cyc("rst0", 0, 0, 0, 0, 0, 0, 0, 0, IDLE, 0, 0);
        cyc("rst1", 0, 0, 1, 2, 2, 2, 0, 1, IDLE, 0, 0);
        cyc("idle", 0, 1, 0, 0, 0, 0, 0, 0, IDLE, 0, 0);
        cyc("lu_rs", 0, 1, 1, 2, 2, 7, 0, 0, BUB, 0, 0);
        cyc("lu1_done", 0, 1, 0, 0, 0, 0, 0, 0, IDLE, 1, 0);
        cyc("ld_r0", 0, 1, 1, 0, 0, 0, 0, 0, IDLE, 1, 0);
        cyc("lu_rt", 0, 1, 1, 3, 4, 3, 0, 0, BUB, 1, 0);
        cyc("no_rd", 0, 1, 0, 3, 3, 3, 0, 0, IDLE, 2, 0);
        cyc("ld_nomatch", 0, 1, 1, 6, 5, 4, 0, 0, IDLE, 2, 0);
        cyc("lu3_a", 1, 1, 1, 5, 5, 0, 0, 0, BUB, 0, 0);
        cyc("lu3_b", 1, 1, 0, 0, 0, 0, 0, 0, BUB, 1, 0);
        cyc("lu3_c", 1, 1, 0, 0, 0, 0, 0, 0, BUB, 2, 0);
        cyc("lu3_end", 1, 1, 0, 0, 0, 0, 0, 0, IDLE, 3, 0);
        cyc("br_a", 1, 1, 1, 5, 0, 5, 0, 0, BUB, 3, 0);
        cyc("br_b", 1, 1, 0, 0, 0, 0, 1, 0, FL, 4, 0);
        cyc("br_end", 1, 1, 0, 0, 0, 0, 0, 0, IDLE, 4, 1);
        cyc("mw_a", 1, 1, 1, 5, 5, 0, 0, 0, BUB, 4, 1);
        for (int i = 0; i < 4; i++)
            cyc("mw_hold", 1, 1, 0, 0, 0, 0, 0, 1, HLD, 16'(5 + i), 1);
        cyc("mw_b2", 1, 1, 0, 0, 0, 0, 0, 0, BUB, 9, 1);
        cyc("mw_b3", 1, 1, 0, 0, 0, 0, 0, 0, BUB, 10, 1);
        cyc("mw_end", 1, 1, 0, 0, 0, 0, 0, 0, IDLE, 11, 1);
        cyc("br_busy", 1, 1, 0, 0, 0, 0, 1, 1, FL, 11, 1);
        cyc("prio_end", 1, 1, 0, 0, 0, 0, 0, 0, IDLE, 11, 2);
        cyc("br_lu", 1, 1, 1, 5, 5, 0, 1, 0, FL, 11, 2);
        cyc("br_lu_end", 1, 1, 0, 0, 0, 0, 0, 0, IDLE, 11, 3);
        for (int i = 0; i < 20; i++)
            cyc("sat_stall", 2, 1, 0, 0, 0, 0, 0, 1, HLD, 16'(i > 15 ? 15 : i), 0);
        cyc("sat_rel", 2, 1, 0, 0, 0, 0, 0, 0, IDLE, 15, 0);
        for (int i = 0; i < 17; i++)
            cyc("sat_flush", 2, 1, 0, 0, 0, 0, 1, 0, FL, 15, 16'(i > 15 ? 15 : i));
        cyc("lu_mid", 2, 1, 1, 9, 9, 0, 0, 0, BUB, 15, 15);
        cyc("mid_rst", 2, 0, 0, 0, 0, 0, 0, 0, IDLE, 0, 0);
        cyc("post_rst", 2, 1, 0, 0, 0, 0, 0, 0, IDLE, 0, 0);
        cyc("post_rst2", 2, 1, 0, 0, 0, 0, 0, 0, IDLE, 0, 0);
        @(posedge clk_i);
        @(posedge clk_i);
        if (q.size() != 0)
            check("drain", 32'(q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
